// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and constants for the I2C slave write controller
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam int   BYTE_BITS    = 8;

endpackage

// File: rtl/i2c_in_sync.sv
// rtl/i2c_in_sync.sv - SCL/SDA synchroniser with edge and START/STOP detection
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   scl_i, sda_i      asynchronous pad inputs
//   scl_s, sda_s      synchronised levels
//   scl_rise/fall     single-cycle SCL edge pulses
//   start_det         SDA falling while SCL held high
//   stop_det          SDA rising while SCL held high
module i2c_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // SYNC_STAGES must be at least 2; the chain shifts in at bit 0.
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Everything resets to the idle-bus level so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_wr_ctrl.sv
// rtl/i2c_slave_wr_ctrl.sv - I2C slave write controller producing register write strobes
// Ports:
//   clk, rst          system clock (>= 8x SCL), synchronous active-high reset
//   scl_i, sda_i      asynchronous pad inputs
//   sda_o             SDA drive, 0 = pull low, 1 = release
//   wr_en             one-cycle register write strobe
//   wr_addr, wr_data  register address/data for wr_en, held between strobes
//   busy              high from an address-matched START until STOP
module i2c_slave_wr_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [3:0] BYTE_CNT = 4'(BYTE_BITS);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_in_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_s    (scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_o_q, sda_o_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_o_d   = sda_o_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (stop_det) begin
      state_d = ST_IDLE;
      sda_o_d = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      // busy is left alone until the new address is judged.
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;

        ST_ADDR, ST_REG, ST_DATA: begin
          // A full byte is acted on the cycle after its last scl_rise.
          if (bit_cnt_q == BYTE_CNT) begin
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR && shift_q[0] == I2C_RW_WRITE) begin
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == ST_REG) begin
              ptr_d   = shift_q;
              state_d = ST_REG_ACK;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = shift_q;
              ptr_d     = ptr_q + 8'd1;
              state_d   = ST_DATA_ACK;
            end
          end else if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end

        ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
          // sda_o itself tracks the ACK phase: released on entry, pulled low
          // on the first SCL fall, released and advanced on the second.
          if (scl_fall && !scl_s) begin
            if (sda_o_q) begin
              sda_o_d = 1'b0;
              if (state_q == ST_ADDR_ACK) busy_d = 1'b1;
            end else begin
              sda_o_d   = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = (state_q == ST_ADDR_ACK) ? ST_REG : ST_DATA;
            end
          end
        end

        ST_IGNORE: sda_o_d = 1'b1;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      ptr_q     <= 8'd0;
      sda_o_q   <= 1'b1;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_o_q   <= sda_o_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign sda_o   = sda_o_q;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_wr_ctrl.sv
// tb/tb_i2c_slave_wr_ctrl.sv - scoreboard bench for the I2C slave write controller
module tb_i2c_slave_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_i, sda_i;
  logic       sda_o, wr_en, busy;
  logic [7:0] wr_addr, wr_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic [7:0]  ptr_m;
  logic [7:0]  tx_buf[0:15];

  always #5 clk = ~clk;

  i2c_slave_wr_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .sda_o  (sda_o),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected (addr,data).
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr actual=%0h/%0h expected=none", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, mon_e[15:8]});
        check("wr_data", {24'd0, wr_data}, {24'd0, mon_e[7:0]});
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    if (scl_i == 1'b0) begin
      sda_i = 1'b1; wait_clks(4);
      scl_i = 1'b1; wait_clks(4);
    end
    sda_i = 1'b0; wait_clks(4);
    scl_i = 1'b0; wait_clks(4);
  endtask

  task automatic send_stop();
    sda_i = 1'b0; wait_clks(4);
    scl_i = 1'b1; wait_clks(4);
    sda_i = 1'b1; wait_clks(4);
  endtask

  task automatic send_bit(input logic b);
    sda_i = b;    wait_clks(4);
    scl_i = 1'b1; wait_clks(8);
    scl_i = 1'b0; wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) send_bit(b[k]);
  endtask

  // Master releases SDA and samples the wired-AND bus mid-high.
  task automatic ack_bit(output logic bus);
    sda_i = 1'b1; wait_clks(4);
    scl_i = 1'b1; wait_clks(4);
    bus = sda_i & sda_o;
    wait_clks(4);
    scl_i = 1'b0; wait_clks(4);
  endtask

  // Reference model: a write to address byte 0xA0 is acknowledged; byte 1 is
  // the pointer; each complete later byte is one write at pointer, pointer+1, ...
  task automatic run_txn(input int n, input bit do_stop);
    bit   acc;
    logic a;
    acc = (tx_buf[0] == 8'hA0);
    send_start();
    for (int i = 0; i < n; i++) begin
      if (acc && i == 1) ptr_m = tx_buf[1];
      if (acc && i >= 2) begin
        exp_q.push_back({ptr_m, tx_buf[i]});
        ptr_m = ptr_m + 8'd1;
      end
      send_byte(tx_buf[i]);
      ack_bit(a);
      check("ack", {31'd0, a}, acc ? 32'd0 : 32'd1);
      check("busy", {31'd0, busy}, {31'd0, acc});
    end
    if (do_stop) begin
      send_stop();
      wait_clks(4);
      check("busy_after_stop", {31'd0, busy}, 32'd0);
      check("pending_writes", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    logic a;
    int   r, n;
    rst = 1'b1; scl_i = 1'b1; sda_i = 1'b1; ptr_m = 8'd0;
    wait_clks(5);
    check("rst_sda_o",   {31'd0, sda_o}, 32'd1);
    check("rst_wr_en",   {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clks(5);

    // Burst write
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h10; tx_buf[2] = 8'h55; tx_buf[3] = 8'hAA;
    run_txn(4, 1);

    // Wrong address
    tx_buf[0] = 8'hA2; tx_buf[1] = 8'h33; tx_buf[2] = 8'h44;
    run_txn(3, 1);

    // Read direction
    tx_buf[0] = 8'hA1; tx_buf[1] = 8'h55;
    run_txn(2, 1);

    // Pointer wrap
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h01; tx_buf[3] = 8'h02;
    run_txn(4, 1);

    // Repeated START after 4 data bits discards the partial byte
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h10;
    run_txn(2, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h20; tx_buf[2] = 8'h33;
    run_txn(3, 1);

    // Reset while the slave holds SDA low for a data ACK
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h40;
    run_txn(2, 0);
    exp_q.push_back({8'h40, 8'h99});
    send_byte(8'h99);
    sda_i = 1'b1;
    wait_clks(4);
    check("data_ack_low", {31'd0, sda_o}, 32'd0);
    rst = 1'b1;
    wait_clks(1);
    check("rst_mid_sda_o",   {31'd0, sda_o}, 32'd1);
    check("rst_mid_busy",    {31'd0, busy}, 32'd0);
    check("rst_mid_wr_addr", {24'd0, wr_addr}, 32'd0);
    rst = 1'b0;
    wait_clks(2);
    send_stop();
    check("pending_after_rst", exp_q.size(), 32'd0);
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h05; tx_buf[2] = 8'h66; tx_buf[3] = 8'h77;
    run_txn(4, 1);

    // Randomised transactions
    for (int t = 0; t < 20; t++) begin
      r = $urandom_range(0, 3);
      if (r <= 1)      tx_buf[0] = 8'hA0;
      else if (r == 2) tx_buf[0] = 8'hA1;
      else             tx_buf[0] = 8'($urandom_range(0, 255));
      n = 2 + $urandom_range(0, 4);
      for (int i = 1; i < n; i++) tx_buf[i] = 8'($urandom_range(0, 255));
      run_txn(n, 1);
    end

    wait_clks(10);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
